// File: rtl/mac_stream_ctrl.sv
// mac_stream_ctrl
//   Collects DEPTH operand pairs from a source over a REQ/ACK strobe handshake,
//   multiplies each pair (one per cycle), then streams DEPTH results to a
//   consumer over a VALID/READY handshake with backpressure. MODE picks
//   per-pair products (0) or a running sum of products (1), latched at START.
//
// Parameters
//   W      operand width, unsigned (>= 2)
//   DEPTH  pairs per job (>= 2)
//   XW     result width, derived: 2*W + clog2(DEPTH)
//
// Ports
//   CLK      clock, rising edge
//   RST      synchronous active-high reset
//   START    begin a job (only honoured while idle)
//   HALT     synchronous abort, same effect as RST
//   MODE     0 = product, 1 = running sum; captured with START
//   A, B     operand pair, captured on REQ_AB & ACK
//   ACK      source strobe: A/B valid this cycle
//   REQ_AB   controller can take a pair this cycle
//   X        result (zero-extended), registered
//   X_VALID  X holds a valid result, registered
//   X_READY  consumer takes X on X_VALID & X_READY
//   BUSY     job in progress (state != idle)
//   DONE     single-cycle pulse in the cycle the last result is accepted

module mac_stream_ctrl #(
  parameter int unsigned  W     = 8,
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned XW    = 2 * W + $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          HALT,
  input  logic          MODE,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  input  logic          ACK,
  output logic          REQ_AB,
  output logic [XW-1:0] X,
  output logic          X_VALID,
  input  logic          X_READY,
  output logic          BUSY,
  output logic          DONE
);

  if (W < 2) begin : g_bad_w
    $error("mac_stream_ctrl: W must be >= 2");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("mac_stream_ctrl: DEPTH must be >= 2");
  end

  // AW addresses the DEPTH-entry buffers; IW must also hold the value DEPTH
  // itself, which marks "all pairs captured" in the input phase.
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = $clog2(DEPTH + 1);

  localparam logic [IW-1:0] IdxLast = IW'(DEPTH - 1);
  localparam logic [IW-1:0] IdxFull = IW'(DEPTH);
  localparam logic [IW-1:0] IdxOne  = IW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StInput,
    StExec,
    StOutput
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic            mode_q;
  logic [XW-1:0]   acc_q;
  logic [XW-1:0]   x_q;
  logic            x_valid_q;

  // Operand and result buffers carry no reset: every entry is rewritten
  // before it is read in any job, and contents after an abort are don't-care.
  logic [W-1:0]    a_mem   [DEPTH];
  logic [W-1:0]    b_mem   [DEPTH];
  logic [XW-1:0]   res_mem [DEPTH];

  logic [AW-1:0]   slot;
  logic [AW-1:0]   slot_nxt;
  logic [2*W-1:0]  prod;
  logic [XW-1:0]   sum;
  logic            take_pair;
  logic            accept;

  // Datapath and decoded outputs
  always_comb begin
    slot      = idx_q[AW-1:0];
    slot_nxt  = AW'(idx_q + IdxOne);
    // Operands are zero-extended first so the product keeps all 2*W bits.
    prod      = {{W{1'b0}}, a_mem[slot]} * {{W{1'b0}}, b_mem[slot]};
    sum       = acc_q + XW'(prod);

    REQ_AB    = (state_q == StInput) && (idx_q != IdxFull);
    take_pair = REQ_AB && ACK;
    accept    = (state_q == StOutput) && x_valid_q && X_READY;

    BUSY      = (state_q != StIdle);
    // DONE has to coincide with the accepting handshake, so it is decoded
    // from registered state plus X_READY rather than registered itself.
    DONE      = accept && (idx_q == IdxLast);

    X         = x_q;
    X_VALID   = x_valid_q;
  end

  // Control FSM with registered result outputs
  always_ff @(posedge CLK) begin
    if (RST || HALT) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      mode_q    <= 1'b0;
      acc_q     <= '0;
      x_q       <= '0;
      x_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (START) begin
            mode_q  <= MODE;
            idx_q   <= '0;
            state_q <= StInput;
          end
        end

        StInput: begin
          if (REQ_AB) begin
            if (ACK) begin
              idx_q <= idx_q + IdxOne;
            end
          end else begin
            // All pairs are in; the accumulator restarts for this job.
            state_q <= StExec;
            idx_q   <= '0;
            acc_q   <= '0;
          end
        end

        StExec: begin
          acc_q <= sum;
          if (idx_q == IdxLast) begin
            // res[0] was written on the first exec cycle, so it is already
            // stable and can be presented right away.
            state_q   <= StOutput;
            idx_q     <= '0;
            x_q       <= res_mem[0];
            x_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IdxOne;
          end
        end

        StOutput: begin
          if (accept) begin
            if (idx_q == IdxLast) begin
              state_q   <= StIdle;
              idx_q     <= '0;
              x_q       <= '0;
              x_valid_q <= 1'b0;
            end else begin
              idx_q <= idx_q + IdxOne;
              x_q   <= res_mem[slot_nxt];
            end
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Operand capture and per-pair results
  always_ff @(posedge CLK) begin
    if (take_pair) begin
      a_mem[slot] <= A;
      b_mem[slot] <= B;
    end
    if (state_q == StExec) begin
      res_mem[slot] <= mode_q ? sum : XW'(prod);
    end
  end

endmodule
